coin_acceptor: RTL

Front-end stage directly upstream of the vending FSM. It converts two raw, bouncy, asynchronous coin-sensor lines into clean single-cycle `half` / `one` credit pulses, which the vending FSM consumes on the same clock. The block also rejects illegal or overlapping insertions, enforces a lockout between credited coins, and keeps saturating coin/reject tallies for service readout.

---
 rtl/coin_acceptor.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises and debounces two coin lines, turns debounced
// rising edges into single-cycle credit/reject pulses, and keeps saturating tallies.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned LOCKOUT  = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_half,
    input  logic             raw_one,
    input  logic             accept_en,
    output logic             half,
    output logic             one,
    output logic             reject,
    output logic [CNT_W-1:0] half_cnt,
    output logic [CNT_W-1:0] one_cnt,
    output logic [CNT_W-1:0] rej_cnt
);

    localparam int unsigned DB_W   = 8;
    localparam int unsigned LK_W   = 8;
    localparam int unsigned ST_W   = 9;
    // A coin held across reset needs this long to reach the debounced level.
    localparam int unsigned SETTLE = DEBOUNCE + 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // Bit 0 is the 50-cent line, bit 1 the 1-dollar line.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d, deb_prev_q;
    logic [1:0][DB_W-1:0]  dbc_q, dbc_d;
    logic [1:0]            ev;

    state_t                state_q, state_d;
    logic [LK_W-1:0]       lock_q, lock_d;
    logic [ST_W-1:0]       settle_q, settle_d;
    logic                  settle_done;

    logic                  half_q, half_d;
    logic                  one_q, one_d;
    logic                  rej_q, rej_d;
    logic                  inc_half, inc_one, inc_rej;
    logic [CNT_W-1:0]      half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0]      one_cnt_q, one_cnt_d;
    logic [CNT_W-1:0]      rej_cnt_q, rej_cnt_d;

    // Synchronisers, debounce state and post-reset settle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dbc_q      <= '0;
            settle_q   <= '0;
        end else begin
            sync1_q    <= {raw_one, raw_half};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dbc_q      <= dbc_d;
            settle_q   <= settle_d;
        end
    end

    always_comb begin
        deb_d = deb_q;
        dbc_d = dbc_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DB_W'(DEBOUNCE - 1)) begin
                deb_d[i] = ~deb_q[i];
                dbc_d[i] = '0;
            end else begin
                dbc_d[i] = dbc_q[i] + DB_W'(1);
            end
        end
    end

    assign ev          = deb_q & ~deb_prev_q;
    assign settle_done = (settle_q == ST_W'(SETTLE));
    assign settle_d    = settle_done ? settle_q : settle_q + ST_W'(1);

    // Control FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_REL;
            lock_q     <= '0;
            half_q     <= 1'b0;
            one_q      <= 1'b0;
            rej_q      <= 1'b0;
            half_cnt_q <= '0;
            one_cnt_q  <= '0;
            rej_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            half_q     <= half_d;
            one_q      <= one_d;
            rej_q      <= rej_d;
            half_cnt_q <= half_cnt_d;
            one_cnt_q  <= one_cnt_d;
            rej_cnt_q  <= rej_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        half_d   = 1'b0;
        one_d    = 1'b0;
        rej_d    = 1'b0;
        inc_half = 1'b0;
        inc_one  = 1'b0;
        inc_rej  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev == 2'b11) begin
                    rej_d   = 1'b1;
                    inc_rej = 1'b1;
                    state_d = WAIT_REL;
                end else if (ev[0]) begin
                    if (!accept_en || deb_q[1]) begin
                        rej_d   = 1'b1;
                        inc_rej = 1'b1;
                        state_d = WAIT_REL;
                    end else begin
                        half_d   = 1'b1;
                        inc_half = 1'b1;
                        lock_d   = '0;
                        state_d  = LOCK;
                    end
                end else if (ev[1]) begin
                    if (!accept_en || deb_q[0]) begin
                        rej_d   = 1'b1;
                        inc_rej = 1'b1;
                        state_d = WAIT_REL;
                    end else begin
                        one_d   = 1'b1;
                        inc_one = 1'b1;
                        lock_d  = '0;
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                if (|ev) begin
                    rej_d   = 1'b1;
                    inc_rej = 1'b1;
                end else if (lock_q == LK_W'(LOCKOUT - 1)) begin
                    state_d = WAIT_REL;
                end else begin
                    lock_d = lock_q + LK_W'(1);
                end
            end
            WAIT_REL: begin
                if (|ev) begin
                    rej_d   = 1'b1;
                    inc_rej = 1'b1;
                end
                if (settle_done && deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_REL;
        endcase
    end

    // Saturating tallies.
    always_comb begin
        half_cnt_d = half_cnt_q;
        one_cnt_d  = one_cnt_q;
        rej_cnt_d  = rej_cnt_q;
        if (inc_half && half_cnt_q != '1) half_cnt_d = half_cnt_q + CNT_W'(1);
        if (inc_one && one_cnt_q != '1)   one_cnt_d  = one_cnt_q + CNT_W'(1);
        if (inc_rej && rej_cnt_q != '1)   rej_cnt_d  = rej_cnt_q + CNT_W'(1);
    end

    assign half     = half_q;
    assign one      = one_q;
    assign reject   = rej_q;
    assign half_cnt = half_cnt_q;
    assign one_cnt  = one_cnt_q;
    assign rej_cnt  = rej_cnt_q;

endmodule
